// File: rtl/game_area_arbiter_if.sv
// Game-logic access bundle for the game-area row store.
// Handshake: the master raises gl_req with gl_we/gl_addr/gl_wdata and holds them
// stable until gl_gnt pulses; the access happens on the clock edge that ends the
// gl_gnt cycle. A read returns gl_rdata with a one-cycle gl_rvalid pulse on the
// cycle after its grant. gl_rdata holds its value between reads.
interface game_area_arbiter_if #(
  parameter int ADDR_W = 5,
  parameter int COLS   = 12
);
  logic              gl_req;
  logic              gl_we;
  logic [ADDR_W-1:0] gl_addr;
  logic [COLS-1:0]   gl_wdata;
  logic              gl_gnt;
  logic [COLS-1:0]   gl_rdata;
  logic              gl_rvalid;

  modport master (
    output gl_req, gl_we, gl_addr, gl_wdata,
    input  gl_gnt, gl_rdata, gl_rvalid
  );

  modport slave (
    input  gl_req, gl_we, gl_addr, gl_wdata,
    output gl_gnt, gl_rdata, gl_rvalid
  );
endinterface

// File: rtl/game_area_arbiter.sv
// Game-area row store with a single port shared by the VGA renderer (priority),
// the game logic (req/gnt) and a bulk-clear engine. Define GA_VBLANK_ONLY_EN to
// restrict game-logic grants and clear writes to vertical blanking.
module game_area_arbiter #(
  parameter int ROWS   = 20,
  parameter int COLS   = 12,
  parameter int ADDR_W = 5
) (
  input  logic                vga_clk,
  input  logic                rst_n,
  input  logic                vid_req,
  input  logic [ADDR_W-1:0]   vid_addr,
  output logic [COLS-1:0]     vid_data,
  input  logic                vblank,
  game_area_arbiter_if.slave  gl,
  input  logic                clr_req,
  output logic                clr_busy,
  output logic                dbg_state
);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ROW = ADDR_W'(ROWS - 1);

  state_t            state_q, state_nx;
  logic [ADDR_W-1:0] cnt_q, cnt_nx;
  logic              gnt;
  logic              clr_wr;
  logic              free;
  logic [COLS-1:0]   rows [ROWS];

`ifdef GA_VBLANK_ONLY_EN
  assign free = !vid_req && vblank;
`else
  logic unused_vblank;
  assign unused_vblank = vblank;
  assign free = !vid_req;
`endif

  always_comb begin
    state_nx = state_q;
    cnt_nx   = cnt_q;
    gnt      = 1'b0;
    clr_wr   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // A clear request wins over a game-logic request in the same cycle.
        if (clr_req) begin
          state_nx = ST_CLEAR;
          cnt_nx   = '0;
        end else if (gl.gl_req && free) begin
          gnt = 1'b1;
        end
      end
      ST_CLEAR: begin
        if (free) begin
          clr_wr = 1'b1;
          if (cnt_q == LAST_ROW) begin
            state_nx = ST_IDLE;
            cnt_nx   = '0;
          end else begin
            cnt_nx = cnt_q + ADDR_W'(1);
          end
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  assign gl.gl_gnt = gnt;
  assign clr_busy  = (state_q == ST_CLEAR);
  assign dbg_state = state_q;

  always_ff @(posedge vga_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      vid_data     <= '0;
      gl.gl_rdata  <= '0;
      gl.gl_rvalid <= 1'b0;
      for (int i = 0; i < ROWS; i++) rows[i] <= '0;
    end else begin
      state_q      <= state_nx;
      cnt_q        <= cnt_nx;
      gl.gl_rvalid <= gnt && !gl.gl_we;
      if (vid_req) vid_data <= (vid_addr <= LAST_ROW) ? rows[vid_addr] : '0;
      if (gnt && !gl.gl_we) gl.gl_rdata <= (gl.gl_addr <= LAST_ROW) ? rows[gl.gl_addr] : '0;
      // Out-of-range writes are granted but leave the store untouched.
      if (gnt && gl.gl_we && (gl.gl_addr <= LAST_ROW)) rows[gl.gl_addr] <= gl.gl_wdata;
      if (clr_wr) rows[cnt_q] <= '0;
    end
  end

endmodule

// File: tb/tb_game_area_arbiter.sv
// Bench for game_area_arbiter: directed scenarios, randomized traffic and a
// cycle-by-cycle comparison against a behavioural model of the row store.
module tb_game_area_arbiter;
  localparam int ROWS   = 20;
  localparam int COLS   = 12;
  localparam int ADDR_W = 5;

  // clock / reset
  logic vga_clk = 1'b0;
  logic rst_n   = 1'b1;
  always #5 vga_clk = ~vga_clk;

  logic              vid_req  = 1'b0;
  logic [ADDR_W-1:0] vid_addr = '0;
  logic              vblank   = 1'b1;
  logic              clr_req  = 1'b0;
  logic [COLS-1:0]   vid_data;
  logic              clr_busy;
  logic              dbg_state;

  game_area_arbiter_if #(.ADDR_W(ADDR_W), .COLS(COLS)) gl_bus ();

  game_area_arbiter #(.ROWS(ROWS), .COLS(COLS), .ADDR_W(ADDR_W)) dut (
    .vga_clk   (vga_clk),
    .rst_n     (rst_n),
    .vid_req   (vid_req),
    .vid_addr  (vid_addr),
    .vid_data  (vid_data),
    .vblank    (vblank),
    .gl        (gl_bus),
    .clr_req   (clr_req),
    .clr_busy  (clr_busy),
    .dbg_state (dbg_state)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // behavioural model of the store and its outputs
  logic [COLS-1:0] mem [ROWS];
  logic [COLS-1:0] m_vid;
  logic [COLS-1:0] m_rdata;
  logic            m_rvalid;
  int              clr_left;
  logic [COLS-1:0] exp_q [$];

  task automatic model_reset();
    for (int i = 0; i < ROWS; i++) mem[i] = '0;
    m_vid    = '0;
    m_rdata  = '0;
    m_rvalid = 1'b0;
    clr_left = 0;
    exp_q.delete();
  endtask

  function automatic logic [COLS-1:0] mem_rd(input logic [ADDR_W-1:0] a);
    return (int'(a) < ROWS) ? mem[a] : '0;
  endfunction

  // scoreboard: compare on every falling edge, then advance the model
  always @(negedge vga_clk) begin
    logic free_now;
    logic exp_gnt;
    if (!rst_n) begin
      model_reset();
      chk("rst_vid_data", 32'(vid_data), 32'h0);
      chk("rst_gl_rdata", 32'(gl_bus.gl_rdata), 32'h0);
      chk("rst_gl_rvalid", 32'(gl_bus.gl_rvalid), 32'h0);
      chk("rst_gl_gnt", 32'(gl_bus.gl_gnt), 32'h0);
      chk("rst_clr_busy", 32'(clr_busy), 32'h0);
    end else begin
`ifdef GA_VBLANK_ONLY_EN
      free_now = !vid_req && vblank;
`else
      free_now = !vid_req;
`endif
      exp_gnt = (clr_left == 0) && !clr_req && gl_bus.gl_req && free_now;
      chk("gl_gnt", 32'(gl_bus.gl_gnt), 32'(exp_gnt));
      chk("vid_data", 32'(vid_data), 32'(m_vid));
      chk("gl_rvalid", 32'(gl_bus.gl_rvalid), 32'(m_rvalid));
      chk("clr_busy", 32'(clr_busy), 32'(clr_left > 0));
      if (gl_bus.gl_rvalid && exp_q.size() > 0) chk("gl_rdata", 32'(gl_bus.gl_rdata), 32'(exp_q.pop_front()));
      else chk("gl_rdata_hold", 32'(gl_bus.gl_rdata), 32'(m_rdata));

      if (vid_req) m_vid = mem_rd(vid_addr);
      m_rvalid = exp_gnt && !gl_bus.gl_we;
      if (exp_gnt && !gl_bus.gl_we) begin
        m_rdata = mem_rd(gl_bus.gl_addr);
        exp_q.push_back(m_rdata);
      end
      if (exp_gnt && gl_bus.gl_we && int'(gl_bus.gl_addr) < ROWS) mem[gl_bus.gl_addr] = gl_bus.gl_wdata;
      if (clr_left > 0) begin
        if (free_now) begin
          mem[ROWS - clr_left] = '0;
          clr_left--;
        end
      end else if (clr_req) begin
        clr_left = ROWS;
      end
    end
  end

  // driver tasks: all start and end one delta past a rising edge
  task automatic step();
    @(posedge vga_clk);
    #1;
  endtask

  task automatic gl_access(input logic we, input logic [ADDR_W-1:0] addr, input logic [COLS-1:0] wd,
                           output int waited, output logic [COLS-1:0] rd);
    bit done;
    gl_bus.gl_req   = 1'b1;
    gl_bus.gl_we    = we;
    gl_bus.gl_addr  = addr;
    gl_bus.gl_wdata = wd;
    waited = 0;
    rd     = '0;
    done   = 1'b0;
    while (!done) begin
      @(negedge vga_clk);
      if (gl_bus.gl_gnt) done = 1'b1;
      else if (waited >= 200) begin
        chk("gnt_timeout", 32'h0, 32'h1);
        done = 1'b1;
      end else waited++;
      if (!done) step();
    end
    step();
    gl_bus.gl_req = 1'b0;
    if (!we) begin
      @(negedge vga_clk);
      chk("rd_rvalid_pulse", 32'(gl_bus.gl_rvalid), 32'h1);
      rd = gl_bus.gl_rdata;
      step();
    end
  endtask

  task automatic vid_read(input logic [ADDR_W-1:0] addr, output logic [COLS-1:0] rd);
    vid_req  = 1'b1;
    vid_addr = addr;
    step();
    vid_req = 1'b0;
    @(negedge vga_clk);
    rd = vid_data;
    step();
  endtask

  int              w;
  int              busy_cnt;
  logic [COLS-1:0] rd;
  bit              gnt_seen;

  initial begin
    gl_bus.gl_req   = 1'b0;
    gl_bus.gl_we    = 1'b0;
    gl_bus.gl_addr  = '0;
    gl_bus.gl_wdata = '0;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge vga_clk);
    #1 rst_n = 1'b1;

    // video sweep after reset, including one out-of-range row
    for (int r = 0; r < ROWS + 2; r++) begin
      vid_read(ADDR_W'(r), rd);
      chk("vid_after_reset", 32'(rd), 32'h0);
    end

    // write, read-after-write on consecutive grants, then video read
    gl_access(1'b1, 5'd3, 12'hA5C, w, rd);
    chk("wr_gnt_same_cycle", 32'(w), 32'h0);
    gl_access(1'b0, 5'd3, 12'h000, w, rd);
    chk("rd_after_wr", 32'(rd), 32'hA5C);
    vid_read(5'd3, rd);
    chk("vid_row3", 32'(rd), 32'hA5C);

    // request held against 10 cycles of video ownership
    fork
      begin
        vid_req  = 1'b1;
        vid_addr = 5'd0;
        repeat (10) @(posedge vga_clk);
        #1 vid_req = 1'b0;
      end
      gl_access(1'b0, 5'd3, 12'h000, w, rd);
    join
    chk("blocked_wait", 32'(w), 32'd10);
    chk("blocked_rdata", 32'(rd), 32'hA5C);

    // out-of-range write is granted, store unchanged
    gl_access(1'b1, 5'd25, 12'hFFF, w, rd);
    chk("oob_wr_gnt", 32'(w), 32'h0);
    gl_access(1'b0, 5'd25, 12'h000, w, rd);
    chk("oob_rd", 32'(rd), 32'h0);

    // fill all rows, then clear with video toggling every cycle
    for (int r = 0; r < ROWS; r++) gl_access(1'b1, ADDR_W'(r), 12'hFFF, w, rd);
    clr_req = 1'b1;
    step();
    clr_req  = 1'b0;
    vid_req  = 1'b1;
    busy_cnt = 0;
    for (int c = 0; c < 200; c++) begin
      @(negedge vga_clk);
      if (!clr_busy) break;
      busy_cnt++;
      step();
      vid_req = !vid_req;
    end
    step();
    vid_req = 1'b0;
    chk("clr_busy_cycles", 32'(busy_cnt), 32'd40);
    for (int r = 0; r < ROWS; r++) begin
      gl_access(1'b0, ADDR_W'(r), 12'h000, w, rd);
      chk("row_after_clear", 32'(rd), 32'h0);
    end

    // clear and game-logic request in the same idle cycle
    fork
      begin
        clr_req = 1'b1;
        step();
        clr_req = 1'b0;
      end
      gl_access(1'b1, 5'd7, 12'h123, w, rd);
    join
    chk("clr_first_wait", 32'(w), 32'd21);
    gl_access(1'b0, 5'd7, 12'h000, w, rd);
    chk("after_clr_rd", 32'(rd), 32'h123);

`ifdef GA_VBLANK_ONLY_EN
    vblank = 1'b0;
    fork
      begin
        repeat (5) @(posedge vga_clk);
        #1 vblank = 1'b1;
      end
      gl_access(1'b1, 5'd5, 12'h3C3, w, rd);
    join
    chk("vblank_wait", 32'(w), 32'd5);
`endif

    // reset in the middle of a clear
    gl_access(1'b1, 5'd9, 12'h777, w, rd);
    clr_req = 1'b1;
    step();
    clr_req = 1'b0;
    vid_req = 1'b1;
    repeat (3) step();
    rst_n = 1'b0;
    step();
    rst_n   = 1'b1;
    vid_req = 1'b0;
    @(negedge vga_clk);
    chk("busy_after_rst", 32'(clr_busy), 32'h0);
    step();
    gl_access(1'b0, 5'd9, 12'h000, w, rd);
    chk("row9_after_rst", 32'(rd), 32'h0);
    gl_access(1'b0, 5'd7, 12'h000, w, rd);
    chk("row7_after_rst", 32'(rd), 32'h0);

    // randomized traffic; requests are held until granted
    gnt_seen = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      vid_req  = ($urandom_range(0, 2) == 0);
      vid_addr = ADDR_W'($urandom_range(0, 23));
      vblank   = ($urandom_range(0, 3) != 0);
      clr_req  = ($urandom_range(0, 99) == 0);
      if (!gl_bus.gl_req || gnt_seen) begin
        gl_bus.gl_req   = ($urandom_range(0, 1) == 1);
        gl_bus.gl_we    = ($urandom_range(0, 1) == 1);
        gl_bus.gl_addr  = ADDR_W'($urandom_range(0, 24));
        gl_bus.gl_wdata = COLS'($urandom_range(0, 4095));
      end
      @(negedge vga_clk);
      gnt_seen = gl_bus.gl_gnt;
      step();
      if ($urandom_range(0, 499) == 0) begin
        rst_n         = 1'b0;
        gl_bus.gl_req = 1'b0;
        clr_req       = 1'b0;
        step();
        rst_n    = 1'b1;
        gnt_seen = 1'b0;
      end
    end
    gl_bus.gl_req = 1'b0;
    clr_req       = 1'b0;
    vid_req       = 1'b0;
    vblank        = 1'b1;
    repeat (3) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
